dwt_lift_sched: RTL
===================

DWT_LIFT_SCHED -- requirements
Module: dwt_lift_sched

Interface
REQ-001 Parameter: H_LAT, default 3, cycles from even_le (pair i+1) to h_valid (pair i).
REQ-002 Parameter: L_LAT, default 2, cycles from h_valid (pair i) to l_valid (pair i).
REQ-003 Parameter: MAX_LEN, default 64, largest supported line length.
REQ-004 Ports: clk  in  1  sole clock, all state on rising edge.
REQ-005 Ports: rst  in  1  asynchronous, active-high reset.
REQ-006 Ports: start  in  1  request a decomposition; sampled only in IDLE.
REQ-007 Ports: line_len  in  7  samples per line; even, 4..MAX_LEN; sampled with start.
REQ-008 Ports: levels  in  2  decomposition levels, 1..3; sampled with start.
REQ-009 Ports: busy  out  1  high from the cycle after an accepted start until DONE completes.
REQ-010 Ports: done  out  1  one-cycle pulse at completion.
REQ-011 Ports: err  out  1  one-cycle pulse when start is rejected.
REQ-012 Ports: rd_en, rd_addr  out  1, 6  sample read request/address; memory read data is valid the next cycle.
REQ-013 Ports: even_le, odd_le  out  1, 1  latch enables for the even/odd sample registers.
REQ-014 Ports: h_sel, l_sel  out  1, 1  boundary select: h_sel=1 right-edge mirror, l_sel=1 left-edge mirror.
REQ-015 Ports: h_valid, l_valid  out  1, 1  high-pass/low-pass result strobes.
REQ-016 Ports: out_idx  out  5  pair index i of the current strobe.
REQ-017 Ports: level  out  2  level in progress (0-based).

Function
REQ-018 FSM states: IDLE, RUN, FLUSH, NEXT_LVL, DONE.
REQ-019 IDLE + start + legal params -> RUN next cycle; n = line_len, level = 0.
REQ-020 Illegal params (odd, <4, >MAX_LEN, levels=0, or line_len>>(levels-1) < 4) -> err pulse next cycle; remain IDLE.
REQ-021 Start while not in IDLE is ignored.
REQ-022 RUN issues n+1 reads on consecutive cycles: rd_addr 0,1,...,n-1, then n-2 (mirror); then -> FLUSH.
REQ-023 even_le/odd_le assert the cycle after each even/odd-address read; the mirror read's even_le carries h_sel=1.
REQ-024 h_valid for pair i asserts H_LAT cycles after even_le of sample 2i+2, with out_idx=i; there are n/2 strobes per level.
REQ-025 l_valid for pair i asserts L_LAT cycles after h_valid of pair i; l_sel=1 only for i=0.
REQ-026 When h_valid and l_valid coincide, out_idx follows l_valid; the datapath recovers the h index as out_idx+1.
REQ-027 FLUSH -> NEXT_LVL the cycle after the last l_valid of the level.
REQ-028 NEXT_LVL (1 cycle): level+1, n>>=1; -> DONE if level+1 == levels, else -> RUN.
REQ-029 DONE (1 cycle): done=1, busy=0; -> IDLE. Levels never overlap.
REQ-030 Timing, first read at cycle s: last l_valid at s+n+6, NEXT_LVL at s+n+7, next RUN or DONE at s+n+8.

Reset
REQ-031 rst (asynchronous, including mid-operation) -> IDLE; every output 0; all counters 0; pending strobes discarded.
REQ-032 The first start is accepted on the first rising clk edge after rst deasserts.

Structure
REQ-033 Shared package dwt_pkg holds the FSM state enum, the h_sel/l_sel encodings, H_LAT/L_LAT defaults, and MAX_LEN.
REQ-034 Sub-module dwt_pulse_dly: parameterised-depth shift register delaying {valid, sel, idx}; one instance each for the H and L strobe paths.

Verification
REQ-035 line_len=8, levels=1, start at t0 -> reads t1..t9 addr 0,1,2,3,4,5,6,7,6; h_valid t7,t9,t11,t13; l_valid t9,t11,t13,t15; done t17.
REQ-036 line_len=8, levels=2 -> level=1 reads at t17..t21 addr 0,1,2,3,2; done t29; busy high t1..t28.
REQ-037 line_len=7, and separately levels=0 -> err pulse at t1; busy stays 0; no rd_en.
REQ-038 line_len=8, levels=3 -> err (8>>2 = 2 < 4); line_len=16, levels=3 -> accepted; done after three levels.
REQ-039 rst asserted at t5 of REQ-035 -> all outputs 0 immediately; a new start at t8 replays the REQ-035 timing.
REQ-040 start held high at t3 mid-run -> ignored; only one done pulse.

Source files
------------

// File: rtl/dwt_pkg.sv
// Shared definitions for the lifting-DWT read/strobe scheduler.
//   dwt_state_t   : scheduler FSM states
//   H_SEL_MIRROR  : h_sel level meaning "use right-edge mirrored sample"
//   L_SEL_MIRROR  : l_sel level meaning "use left-edge mirrored result"
//   *_DEF         : default latencies and maximum line length
package dwt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
    NEXT_LVL,
    DONE
  } dwt_state_t;

  localparam logic H_SEL_MIRROR = 1'b1;
  localparam logic L_SEL_MIRROR = 1'b1;

  localparam int H_LAT_DEF   = 3;
  localparam int L_LAT_DEF   = 2;
  localparam int MAX_LEN_DEF = 64;

endpackage

// File: rtl/dwt_pulse_dly.sv
// Fixed-depth delay line for a strobe with its select bit and pair index.
//   clk, rst          : clock, asynchronous active-high reset (flushes strobes)
//   in_vld/sel/idx    : strobe entering the line
//   out_vld/sel/idx   : same strobe DEPTH cycles later
module dwt_pulse_dly #(
  parameter int DEPTH = 3,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_sel,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic             out_sel,
  output logic [IDX_W-1:0] out_idx
);

  logic [IDX_W+1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {in_vld, in_sel, in_idx};
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_vld = pipe[DEPTH-1][IDX_W+1];
  assign out_sel = pipe[DEPTH-1][IDX_W];
  assign out_idx = pipe[DEPTH-1][IDX_W-1:0];

endmodule

// File: rtl/dwt_lift_sched.sv
// Read/latch/strobe scheduler for a multi-level 1-D lifting DWT.
//   clk, rst            : clock, asynchronous active-high reset
//   start, line_len,
//   levels              : decomposition request (sampled in IDLE)
//   busy, done, err     : status (done/err are one-cycle pulses)
//   rd_en, rd_addr      : sample memory read, data valid next cycle
//   even_le, odd_le     : even/odd sample register latch enables
//   h_sel, l_sel        : boundary mirror selects
//   h_valid, l_valid    : high-/low-pass result strobes
//   out_idx             : pair index of the current strobe (l_valid wins)
//   level               : level in progress, 0-based
module dwt_lift_sched
  import dwt_pkg::*;
#(
  parameter int H_LAT   = H_LAT_DEF,
  parameter int L_LAT   = L_LAT_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] line_len,
  input  logic [1:0] levels,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rd_en,
  output logic [5:0] rd_addr,
  output logic       even_le,
  output logic       odd_le,
  output logic       h_sel,
  output logic       l_sel,
  output logic       h_valid,
  output logic       l_valid,
  output logic [4:0] out_idx,
  output logic [1:0] level
);

  dwt_state_t state, state_nxt;
  logic [6:0] n_q, cnt_q;
  logic [1:0] lvls_q, level_q;
  logic       err_q;
  logic       params_ok, last_rd, last_l;
  logic [6:0] addr_p0;

  logic       even_le_p1, odd_le_p1, mirror_p1;
  logic [5:0] pair_p1;

  logic       h_in_vld, h_in_sel, l_in_sel;
  logic [4:0] h_in_idx;
  logic       vld_p2h, sel_p2h, vld_p3l, sel_p3l;
  logic [4:0] idx_p2h, idx_p3l;

  // Every level must still hold at least two pairs after all halvings.
  always_comb begin
    params_ok = !line_len[0] && (line_len >= 7'd4) && (int'(line_len) <= MAX_LEN) &&
                (levels != 2'd0) && ((line_len >> (levels - 2'd1)) >= 7'd4);
  end

  assign last_rd = (cnt_q == n_q);
  assign last_l  = vld_p3l && ({1'b0, idx_p3l} == (n_q[6:1] - 6'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && params_ok) state_nxt = RUN;
      RUN:      if (last_rd) state_nxt = FLUSH;
      FLUSH:    if (last_l) state_nxt = NEXT_LVL;
      NEXT_LVL: state_nxt = ((level_q + 2'd1) == lvls_q) ? DONE : RUN;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q     <= '0;
      cnt_q   <= '0;
      lvls_q  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start && !params_ok;
      case (state)
        IDLE: begin
          if (start && params_ok) begin
            n_q     <= line_len;
            lvls_q  <= levels;
            level_q <= '0;
            cnt_q   <= '0;
          end
        end
        RUN: cnt_q <= cnt_q + 7'd1;
        NEXT_LVL: begin
          n_q   <= n_q >> 1;
          cnt_q <= '0;
          if (state_nxt == RUN) level_q <= level_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Stage p0: read request; the extra read re-fetches sample n-2 as the right-edge mirror.
  assign rd_en   = (state == RUN);
  assign addr_p0 = last_rd ? (n_q - 7'd2) : cnt_q;
  assign rd_addr = rd_en ? addr_p0[5:0] : 6'd0;

  // Stage p1: read data arrives; latch enables and the sample's pair number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      even_le_p1 <= 1'b0;
      odd_le_p1  <= 1'b0;
      mirror_p1  <= 1'b0;
      pair_p1    <= '0;
    end else begin
      even_le_p1 <= rd_en && !addr_p0[0];
      odd_le_p1  <= rd_en && addr_p0[0];
      mirror_p1  <= rd_en && last_rd;
      pair_p1    <= !rd_en ? 6'd0 : (last_rd ? n_q[6:1] : addr_p0[6:1]);
    end
  end

  // Even sample 2i+2 completes pair i; sample 0 only primes the pipeline.
  assign h_in_vld = even_le_p1 && (pair_p1 != 6'd0);
  assign h_in_idx = h_in_vld ? 5'(pair_p1 - 6'd1) : 5'd0;
  assign h_in_sel = (even_le_p1 && mirror_p1) ? H_SEL_MIRROR : 1'b0;

  // Stage p2: high-pass strobe after H_LAT.
  dwt_pulse_dly #(.DEPTH(H_LAT), .IDX_W(5)) u_h_dly (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (h_in_vld),
    .in_sel  (h_in_sel),
    .in_idx  (h_in_idx),
    .out_vld (vld_p2h),
    .out_sel (sel_p2h),
    .out_idx (idx_p2h)
  );

  assign l_in_sel = (vld_p2h && (idx_p2h == 5'd0)) ? L_SEL_MIRROR : 1'b0;

  // Stage p3: low-pass strobe L_LAT after its high-pass partner.
  dwt_pulse_dly #(.DEPTH(L_LAT), .IDX_W(5)) u_l_dly (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (vld_p2h),
    .in_sel  (l_in_sel),
    .in_idx  (idx_p2h),
    .out_vld (vld_p3l),
    .out_sel (sel_p3l),
    .out_idx (idx_p3l)
  );

  assign even_le = even_le_p1;
  assign odd_le  = odd_le_p1;
  // h_sel marks the mirrored sample when it is latched and again when the
  // last high-pass result that consumes it is strobed.
  assign h_sel   = h_in_sel | sel_p2h;
  assign l_sel   = sel_p3l;
  assign h_valid = vld_p2h;
  assign l_valid = vld_p3l;
  assign out_idx = vld_p3l ? idx_p3l : idx_p2h;
  assign busy    = (state inside {RUN, FLUSH, NEXT_LVL});
  assign done    = (state == DONE);
  assign err     = err_q;
  assign level   = level_q;

endmodule
